// File: rtl/seq_detect_ctrl.sv
// Serial pattern-detect sequencer: shifts a latched word out MSB-first and
// runs an overlapping Mealy match of a latched pattern, counting hits.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      request to scan data_in (sampled in IDLE only)
//   data_in    DATA_W-bit word, latched on start acceptance
//   pattern    PAT_W-bit pattern, MSB is the oldest bit
//   busy       high in SHIFT and DONE
//   ser_valid  high while a stream bit is presented
//   ser_bit    current stream bit (MSB of the shift register)
//   match      high in the cycle whose ser_bit completes a match
//   done       one-cycle pulse after the last bit
//   match_cnt  saturating match count for the current/last word
//
// Build option: define SEQ_DETECT_SPAN_EN to keep match history across
// starts so a pattern can straddle consecutive words.
module seq_detect_ctrl #(
  parameter int DATA_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [PAT_W-1:0]  pattern,
  output logic              busy,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              match,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int HV_W = $clog2(PAT_W);

  localparam logic [BC_W-1:0] LAST =
    BC_W'(DATA_W - 1);
  localparam logic [HV_W-1:0] HV_FULL =
    HV_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [PAT_W-1:0]  pat;
  logic [PAT_W-2:0]  hist;
  logic [HV_W-1:0]   hvalid;
  logic [BC_W-1:0]   bcnt;
  logic [PAT_W-1:0]  window;

  assign ser_bit = sreg[DATA_W-1];

  // Newest PAT_W bits of the stream, oldest at the MSB.
  assign window = {hist, ser_bit};

  assign match = ser_valid
              && (hvalid == HV_FULL)
              && (window == pat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sreg      <= '0;
      pat       <= '0;
      hist      <= '0;
      hvalid    <= '0;
      bcnt      <= '0;
      match_cnt <= '0;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg      <= data_in;
            pat       <= pattern;
            match_cnt <= '0;
            bcnt      <= '0;
`ifdef SEQ_DETECT_SPAN_EN
            // History carries over so matches
            // may straddle word boundaries.
            hist      <= hist;
            hvalid    <= hvalid;
`else
            hist      <= '0;
            hvalid    <= '0;
`endif
            state     <= S_SHIFT;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
          end
        end

        S_SHIFT: begin
          sreg <= sreg << 1;
          hist <= window[PAT_W-2:0];
          bcnt <= bcnt + 1'b1;
          if (hvalid != HV_FULL)
            hvalid <= hvalid + 1'b1;
          if (match && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
          if (bcnt == LAST) begin
            state     <= S_DONE;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller that sequences a serial pattern detector over parallel data words.
- Accepts a DATA_W-bit word and a PAT_W-bit pattern on a start request, then shifts the word out MSB-first, one bit per clock.
- Runs a Mealy-style overlapping match on the serial stream, counts matches and signals completion.
- Sits between a register/host interface and the serial detection datapath; it replaces hand-driven stimulus of fixed-pattern detectors.

Parameters:
- DATA_W, 16, bits per word shifted out; legal range DATA_W >= PAT_W.
- PAT_W, 4, pattern length in bits; legal range PAT_W >= 2.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request to process data_in; sampled only in IDLE
- data_in  input  DATA_W  word to scan; latched on start acceptance
- pattern  input  PAT_W  pattern to detect; latched on start acceptance; bit PAT_W-1 is the oldest bit
- busy  output  1  high in SHIFT and DONE
- ser_valid  output  1  high while a stream bit is presented (SHIFT only)
- ser_bit  output  1  current stream bit; MSB of the shift register
- match  output  1  Mealy output: high in the cycle whose ser_bit completes a pattern match
- done  output  1  one-cycle pulse after the last bit
- match_cnt  output  CNT_W  matches found in the current or last word

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Shift register, history, bit counter and match_cnt all cleared to 0.
  - Outputs busy=0, ser_valid=0, match=0, done=0.
  - Reset asserted mid-operation aborts the word immediately; no done pulse is issued.
- States: IDLE, SHIFT, DONE. Encoding is free; an unreachable state returns to IDLE.
- IDLE:
  - If start=1 at a rising edge: latch data_in and pattern, clear match_cnt and bit counter, clear history (see Optional Feature), go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - ser_valid=1; ser_bit is the MSB of the shift register.
  - Each edge shifts the register left by one, shifts ser_bit into the history and increments the bit counter.
  - After DATA_W bits have been presented, go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge k; bits are presented in cycles k+1 .. k+DATA_W; done is high in cycle k+DATA_W+1; a new start is accepted no earlier than the edge ending cycle k+DATA_W+1.
- Match rule (combinational, Mealy):
  - match = ser_valid AND (history holds at least PAT_W-1 valid bits) AND ({history[PAT_W-2:0], ser_bit} == pattern).
  - Detection is overlapping: history is never cleared on a match.
  - The history valid count saturates at PAT_W-1.
- match_cnt:
  - Increments at each edge where match=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Holds its value in DONE and IDLE until the next start.
- start while busy=1 is ignored: no relatch, and the in-flight word is unaffected.
- data_in and pattern changes after acceptance have no effect.
- start held high continuously causes back-to-back words: one idle cycle between words, plus the DONE cycle.

Optional Feature:
- Macro: SEQ_DETECT_SPAN_EN.
- Defined: history and its valid count are NOT cleared on start. A pattern may straddle consecutive words, and matches can occur from the first bit of a word. Reset still clears history.
- Undefined: history and valid count are cleared on every start. The first possible match is at bit PAT_W of each word.

Test Plan:
1. Overlapping match: pattern=4'b0101, data_in=16'h5555, start one cycle -> ser_bit sequence 0,1,0,1,...; match high on bits 4,6,8,10,12,14,16; match_cnt=7; done pulses in cycle k+17.
2. Repeated pattern: pattern=4'b0000, data_in=16'h0000 -> match high on bits 4..16; match_cnt=13.
3. No match: pattern=4'b1111, data_in=16'h0000 -> match never high; match_cnt=0; done pulses once; busy drops after DONE.
4. Busy lockout: start word 16'h5555 with pattern 0101; pulse start with data_in=16'hFFFF at bit 5 -> ignored; match_cnt=7; exactly one done pulse.
5. Reset mid-word: assert rst=0 at bit 8 of scenario 1 -> all outputs 0 immediately, state IDLE, no done; after release, a new start runs a full word correctly.
6. Span feature: pattern=4'b0101, word 16'h0002 then word 16'h8000 -> first word match_cnt=0. Second word: with SEQ_DETECT_SPAN_EN, match on its first bit and match_cnt=1; without it, match_cnt=0.
